// File: rtl/dtree_pkg.sv
// Shared constants, FSM state type and slot-slicing helper for the
// decision-tree frame sequencer.
package dtree_pkg;

  localparam int unsigned FEAT_W = 8;
  localparam int unsigned N_FEAT = 5;

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    RESULT
  } state_t;

  // LSB position of feature slot `slot` on the flat feature bus
  function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned width);
    return slot * width;
  endfunction

endpackage

// File: rtl/dtree_frame_sequencer_if.sv
// Feature byte stream (s_*) and classification result channel (m_*) of the
// frame sequencer, grouped as one valid/ready bundle.
interface dtree_frame_sequencer_if #(
  parameter int unsigned FEAT_W = dtree_pkg::FEAT_W,
  parameter int unsigned OUT_W  = 1
);

  logic              s_valid;
  logic              s_ready;
  logic [FEAT_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_class;
  logic              m_err;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_class, m_err
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_class, m_err
  );

endinterface

// File: rtl/dtree_frame_sequencer.sv
// Serialises feature bytes into the parallel bus of a combinational tree,
// waits SETTLE cycles, then returns the sampled class on a result channel.
module dtree_frame_sequencer #(
  parameter int unsigned N_FEAT = dtree_pkg::N_FEAT,
  parameter int unsigned FEAT_W = dtree_pkg::FEAT_W,
  parameter int unsigned OUT_W  = 1,
  parameter int unsigned SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dtree_frame_sequencer_if.slave   bus,
  output logic [N_FEAT*FEAT_W-1:0] feat_o,
  input  logic [OUT_W-1:0]         cls_i
);

  import dtree_pkg::state_t;
  import dtree_pkg::slot_lsb;

  localparam int unsigned IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic               err;
  logic               s_ready_q;
  logic               m_valid_q;
  logic [OUT_W-1:0]   m_class_q;
  logic               m_err_q;

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_class = m_class_q;
  assign bus.m_err   = m_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= dtree_pkg::LOAD;
      idx       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      s_ready_q <= 1'b0;
      feat_o    <= '0;
      m_valid_q <= 1'b0;
      m_class_q <= '0;
      m_err_q   <= 1'b0;
    end else begin
      case (state)
        dtree_pkg::LOAD: begin
          s_ready_q <= 1'b1;
          if (bus.s_valid && s_ready_q) begin
            feat_o[slot_lsb(32'(idx), FEAT_W) +: FEAT_W] <= bus.s_data;
            if ((idx == IDX_W'(N_FEAT - 1)) || bus.s_last) begin
              // A short frame leaves its upper slots zeroed, not stale
              for (int unsigned i = 0; i < N_FEAT; i++) begin
                if (i > 32'(idx)) begin
                  feat_o[slot_lsb(i, FEAT_W) +: FEAT_W] <= '0;
                end
              end
              err       <= (idx == IDX_W'(N_FEAT - 1)) ? ~bus.s_last : 1'b1;
              cnt       <= CNT_W'(SETTLE - 1);
              s_ready_q <= 1'b0;
              state     <= dtree_pkg::SETTLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        dtree_pkg::SETTLE: begin
          s_ready_q <= 1'b0;
          if (cnt == '0) begin
            m_class_q <= cls_i;
            m_err_q   <= err;
            m_valid_q <= 1'b1;
            state     <= dtree_pkg::RESULT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        dtree_pkg::RESULT: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            idx       <= '0;
            err       <= 1'b0;
            s_ready_q <= 1'b1;
            state     <= dtree_pkg::LOAD;
          end else begin
            s_ready_q <= 1'b0;
          end
        end

        default: begin
          s_ready_q <= 1'b0;
          state     <= dtree_pkg::LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_frame_sequencer.sv
// Directed, table-driven bench for dtree_frame_sequencer: frame table plus
// hand-written reset and backpressure sequences.
module tb_dtree_frame_sequencer;

  localparam int unsigned SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [39:0] feat;
  logic        cls;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  dtree_frame_sequencer_if #(.FEAT_W(8), .OUT_W(1)) bus ();

  dtree_frame_sequencer #(
    .N_FEAT(5),
    .FEAT_W(8),
    .OUT_W (1),
    .SETTLE(SETTLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .feat_o(feat),
    .cls_i (cls)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [39:0] bytes;
    int unsigned n;
    logic        last_on_final;
    logic        cls;
    logic [39:0] exp_feat;
    logic        exp_err;
  } frame_t;

  frame_t frames [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input frame_t f);
    int unsigned w;
    logic [39:0] b;
    b = f.bytes;
    cls = f.cls;
    for (int unsigned k = 0; k < f.n; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = b[8*k +: 8];
      bus.s_last  = (k == f.n - 1) && f.last_on_final;
      w = 0;
      while (!bus.s_ready && w < 20) begin
        tick();
        w++;
      end
      if (w >= 20) begin
        check({f.name, "_s_ready_timeout"}, 64'd0, 64'd1);
        break;
      end
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic run_frame(input frame_t f, input bit backpressure);
    int unsigned lat;
    bit stable;
    send_bytes(f);
    check({f.name, "_s_ready_fall"}, 64'(bus.s_ready), 64'd0);
    lat = 0;
    while (!bus.m_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({f.name, "_latency"}, 64'(lat), 64'(SETTLE));
    check({f.name, "_feat"},    64'(feat), 64'(f.exp_feat));
    check({f.name, "_class"},   64'(bus.m_class), 64'(f.cls));
    check({f.name, "_err"},     64'(bus.m_err), 64'(f.exp_err));
    if (backpressure) begin
      stable = 1'b1;
      cls = ~f.cls;
      for (int unsigned c = 0; c < 10; c++) begin
        bus.s_valid = 1'b1;
        bus.s_data  = 8'($urandom);
        bus.s_last  = 1'($urandom);
        tick();
        if (!(bus.m_valid === 1'b1 && bus.m_class === f.cls && bus.m_err === f.exp_err
              && feat === f.exp_feat && bus.s_ready === 1'b0)) stable = 1'b0;
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      check({f.name, "_backpressure_hold"}, 64'(stable), 64'd1);
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    check({f.name, "_m_valid_drop"}, 64'(bus.m_valid), 64'd0);
    check({f.name, "_s_ready_rise"}, 64'(bus.s_ready), 64'd1);
  endtask

  initial begin
    int unsigned seen;
    frame_t f;

    frames[0] = '{"nominal",  40'h50_40_30_20_10, 5, 1'b1, 1'b1, 40'h50_40_30_20_10, 1'b0};
    frames[1] = '{"early",    40'h00_00_CC_BB_AA, 3, 1'b1, 1'b0, 40'h00_00_CC_BB_AA, 1'b1};
    frames[2] = '{"good",     40'h05_04_03_02_01, 5, 1'b1, 1'b0, 40'h05_04_03_02_01, 1'b0};
    frames[3] = '{"nolast",   40'h0A_0B_0C_0D_0E, 5, 1'b0, 1'b1, 40'h0A_0B_0C_0D_0E, 1'b1};
    frames[4] = '{"single",   40'h00_00_00_00_77, 1, 1'b1, 1'b1, 40'h00_00_00_00_77, 1'b1};
    frames[5] = '{"nominal2", 40'hBB_CC_DD_EE_FF, 5, 1'b1, 1'b0, 40'hBB_CC_DD_EE_FF, 1'b0};

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    cls         = 1'b0;

    // Reset with stimulus toggling
    #2 rst_n = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      bus.s_valid = ~bus.s_valid;
      bus.s_data  = 8'($urandom);
      bus.s_last  = ~bus.s_last;
      bus.m_ready = ~bus.m_ready;
      cls         = ~cls;
      tick();
      check("reset_outputs_zero",
            64'({bus.s_ready, bus.m_valid, bus.m_class, bus.m_err, feat}), 64'd0);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check("s_ready_low_at_release", 64'(bus.s_ready), 64'd0);
    tick();
    check("s_ready_after_release", 64'(bus.s_ready), 64'd1);

    for (int unsigned i = 0; i < 6; i++) run_frame(frames[i], i == 0);

    // Reset while the tree is settling
    f = frames[5];
    f.name = "midsettle";
    send_bytes(f);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midsettle_feat_cleared", 64'(feat), 64'd0);
    check("midsettle_m_valid_low", 64'(bus.m_valid), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int unsigned c = 0; c < SETTLE + 4; c++) begin
      tick();
      if (bus.m_valid) seen++;
    end
    check("midsettle_no_result", 64'(seen), 64'd0);
    check("midsettle_feat_still_zero", 64'(feat), 64'd0);

    f = frames[0];
    f.name = "post_reset";
    run_frame(f, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
